// File: rtl/serial_paralelo_rx.sv
// -----------------------------------------------------------------------------
// serial_paralelo_rx
//   Receive side of the parallel-to-serial link. Shifts in an MSB-first serial
//   stream, locks byte alignment on COMMA idle symbols, declares the link
//   active after COM_COUNT consecutive aligned COMMAs, and then delivers each
//   non-COMMA byte with a one-cycle valid strobe. COMMAs are idle and dropped.
//
// Parameters
//   COMMA      idle/alignment symbol (default 8'hBC)
//   COM_COUNT  aligned COMMAs needed to go active (1..15, default 4)
//
// Ports
//   clk32_f    in   bit clock, all logic on the rising edge
//   reset      in   synchronous active-high reset
//   data_in    in   serial bit, MSB of each byte first
//   data_out   out  [7:0] recovered byte, holds between strobes
//   valid_out  out  one-cycle strobe per recovered non-COMMA byte
//   active     out  link aligned (sticky until reset)
// -----------------------------------------------------------------------------
module serial_paralelo_rx #(
  parameter logic [7:0]  COMMA     = 8'hBC,
  parameter int unsigned COM_COUNT = 4
) (
  input  logic       clk32_f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

  typedef enum logic [1:0] {
    S_UNSYNC = 2'd0,
    S_ALIGN  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [6:0] r_sr;
  logic [2:0] r_bit_cnt;
  logic [2:0] w_bit_cnt_next;
  logic [3:0] r_com_cnt;
  logic [3:0] w_com_cnt_next;
  logic [3:0] w_com_inc;

  logic [7:0] r_data_out;
  logic [7:0] w_data_out_next;
  logic       r_valid;
  logic       w_valid_next;
  logic       r_active;
  logic       w_active_next;

  logic [7:0] w_win;
  logic       w_is_comma;
  logic       w_boundary;

  // The window includes the bit being sampled this cycle, so a byte is
  // recognised on the same edge that captures its last bit.
  assign w_win      = {r_sr, data_in};
  assign w_is_comma = (w_win == COMMA);
  assign w_boundary = (r_bit_cnt == 3'd7);
  assign w_com_inc  = r_com_cnt + 4'd1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk32_f) begin
    if (reset) begin
      r_state <= S_UNSYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_UNSYNC: begin
        // Searches every bit phase; the first hit fixes the byte phase.
        if (w_is_comma) begin
          w_state_next = (COM_TARGET == 4'd1) ? S_ACTIVE : S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (w_boundary) begin
          if (!w_is_comma) begin
            w_state_next = S_UNSYNC;
          end else if (w_com_inc == COM_TARGET) begin
            w_state_next = S_ACTIVE;
          end
        end
      end
      S_ACTIVE: begin
        // No loss-of-sync detection: only reset leaves ACTIVE.
        w_state_next = S_ACTIVE;
      end
      default: begin
        w_state_next = S_UNSYNC;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / counter next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_bit_cnt_next  = r_bit_cnt + 3'd1;
    w_com_cnt_next  = r_com_cnt;
    w_data_out_next = r_data_out;
    w_valid_next    = 1'b0;
    w_active_next   = r_active;
    case (r_state)
      S_UNSYNC: begin
        // The bit counter is meaningless until a COMMA is found; hold it.
        w_bit_cnt_next = r_bit_cnt;
        if (w_is_comma) begin
          w_bit_cnt_next = 3'd0;
          w_com_cnt_next = 4'd1;
          if (COM_TARGET == 4'd1) begin
            w_active_next = 1'b1;
          end
        end
      end
      S_ALIGN: begin
        if (w_boundary) begin
          if (w_is_comma) begin
            w_com_cnt_next = w_com_inc;
            if (w_com_inc == COM_TARGET) begin
              w_active_next = 1'b1;
            end
          end else begin
            w_com_cnt_next = 4'd0;
          end
        end
      end
      S_ACTIVE: begin
        if (w_boundary && !w_is_comma) begin
          w_data_out_next = w_win;
          w_valid_next    = 1'b1;
        end
      end
      default: begin
        w_bit_cnt_next = 3'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk32_f) begin
    if (reset) begin
      r_sr       <= 7'd0;
      r_bit_cnt  <= 3'd0;
      r_com_cnt  <= 4'd0;
      r_data_out <= 8'h00;
      r_valid    <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_sr       <= {r_sr[5:0], data_in};
      r_bit_cnt  <= w_bit_cnt_next;
      r_com_cnt  <= w_com_cnt_next;
      r_data_out <= w_data_out_next;
      r_valid    <= w_valid_next;
      r_active   <= w_active_next;
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid;
  assign active    = r_active;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_paralelo_rx
//   Directed scenario bench for serial_paralelo_rx. Expected bytes are pushed
//   into a scoreboard queue as they are serialised and popped when the strobe
//   appears on the edge that samples the byte's last bit.
// -----------------------------------------------------------------------------
module tb_serial_paralelo_rx;

  localparam logic [7:0] COMMA = 8'hBC;

  logic       clk32_f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int         n_checks;
  int         n_fail;
  int         cyc;
  logic [7:0] exp_q[$];

  serial_paralelo_rx #(
    .COMMA     (COMMA),
    .COM_COUNT (4)
  ) dut (
    .clk32_f   (clk32_f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active)
  );

  initial clk32_f = 1'b0;
  always #5 clk32_f = ~clk32_f;

  always @(posedge clk32_f) cyc <= cyc + 1;

  // Drive one bit, let the edge sample it, then look at the outputs 1ns later.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk32_f);
    #1;
  endtask

  // Serialise a byte MSB first. valid_out must stay low on the first seven
  // bits; on the last bit it must match exp_valid, and a strobe must carry
  // the byte at the head of the scoreboard.
  task automatic send_byte(input logic [7:0] b, input logic exp_valid);
    logic [7:0] exp_b;
    if (exp_valid) exp_q.push_back(b);
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      n_checks++;
      if (i != 0) begin
        if (valid_out !== 1'b0) begin
          $display("FAIL mid_byte_valid: byte %h bit %0d valid_out=%b required 0", b, i, valid_out);
          n_fail++;
        end
      end else begin
        if (valid_out !== exp_valid) begin
          $display("FAIL byte_valid: byte %h valid_out=%b required %b", b, valid_out, exp_valid);
          n_fail++;
        end
      end
    end
    if (valid_out === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_strobe: data_out=%h with empty scoreboard", data_out);
        n_fail++;
      end else begin
        exp_b = exp_q.pop_front();
        if (data_out !== exp_b) begin
          $display("FAIL rx_data: data_out=%h required %h", data_out, exp_b);
          n_fail++;
        end
      end
    end
    $display("tx %h cycle %0d valid_out=%b data_out=%h active=%b", b, cyc, valid_out, data_out, active);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      data_in = 1'($urandom);
      @(posedge clk32_f);
      #1;
    end
    reset = 1'b0;
  endtask

  task automatic check_active(input logic exp, input string tag);
    n_checks++;
    if (active !== exp) begin
      $display("FAIL %s: active=%b required %b", tag, active, exp);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    do_reset(3);
    n_checks++;
    if (data_out !== 8'h00 || valid_out !== 1'b0 || active !== 1'b0) begin
      $display("FAIL reset_state: data_out=%h valid_out=%b active=%b required 00/0/0", data_out, valid_out, active);
      n_fail++;
    end
    $display("reset done cycle %0d", cyc);
  endtask

  task automatic test_align_basic();
    int t0;
    do_reset(2);
    for (int k = 0; k < 3; k++) send_byte(COMMA, 1'b0);
    check_active(1'b0, "basic_active_after_3_comma");
    // Active must not appear before the last bit of the 4th COMMA.
    for (int i = 7; i >= 1; i--) send_bit(COMMA[i]);
    check_active(1'b0, "basic_active_before_last_bit");
    send_bit(COMMA[0]);
    check_active(1'b1, "basic_active_on_4th_comma");
    send_byte(8'hA5, 1'b1);
    t0 = cyc;
    send_byte(8'h3C, 1'b1);
    n_checks++;
    if (cyc - t0 != 8) begin
      $display("FAIL basic_strobe_gap: gap=%0d required 8", cyc - t0);
      n_fail++;
    end
  endtask

  task automatic test_junk_prefix();
    do_reset(2);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int k = 0; k < 3; k++) send_byte(COMMA, 1'b0);
    check_active(1'b0, "junk_active_after_3_comma");
    send_byte(COMMA, 1'b0);
    check_active(1'b1, "junk_active_after_4_comma");
    send_byte(8'h5A, 1'b1);
  endtask

  task automatic test_align_fail();
    do_reset(2);
    for (int k = 0; k < 3; k++) send_byte(COMMA, 1'b0);
    send_byte(8'h77, 1'b0);
    check_active(1'b0, "fail_active_after_77");
    for (int k = 0; k < 3; k++) send_byte(COMMA, 1'b0);
    check_active(1'b0, "fail_active_after_3_new_comma");
    send_byte(COMMA, 1'b0);
    check_active(1'b1, "fail_active_after_4_new_comma");
    send_byte(8'h11, 1'b1);
  endtask

  task automatic test_back_to_back();
    int t0;
    do_reset(2);
    for (int k = 0; k < 4; k++) send_byte(COMMA, 1'b0);
    check_active(1'b1, "b2b_active");
    send_byte(8'hA5, 1'b1);
    t0 = cyc;
    for (int k = 0; k < 2; k++) begin
      send_byte(COMMA, 1'b0);
      n_checks++;
      if (data_out !== 8'hA5) begin
        $display("FAIL b2b_hold: data_out=%h required a5", data_out);
        n_fail++;
      end
    end
    send_byte(8'hC3, 1'b1);
    n_checks++;
    if (cyc - t0 != 24) begin
      $display("FAIL b2b_strobe_gap: gap=%0d required 24", cyc - t0);
      n_fail++;
    end
  endtask

  task automatic test_reset_active();
    logic [7:0] b;
    do_reset(2);
    for (int k = 0; k < 4; k++) send_byte(COMMA, 1'b0);
    send_byte(8'h96, 1'b1);
    check_active(1'b1, "rst_active_before");
    // Reset in the middle of a byte.
    b = 8'hE7;
    for (int i = 7; i >= 4; i--) send_bit(b[i]);
    do_reset(1);
    n_checks++;
    if (active !== 1'b0 || valid_out !== 1'b0 || data_out !== 8'h00) begin
      $display("FAIL rst_mid_byte: data_out=%h valid_out=%b active=%b required 00/0/0", data_out, valid_out, active);
      n_fail++;
    end
    for (int k = 0; k < 3; k++) send_byte(COMMA, 1'b0);
    check_active(1'b0, "rst_realign_after_3");
    send_byte(COMMA, 1'b0);
    check_active(1'b1, "rst_realign_after_4");
    send_byte(8'h99, 1'b1);
    // Reset on the boundary edge of a data byte: reset wins.
    b = 8'h42;
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
    reset   = 1'b1;
    data_in = b[0];
    @(posedge clk32_f);
    #1;
    reset = 1'b0;
    n_checks++;
    if (valid_out !== 1'b0 || data_out !== 8'h00 || active !== 1'b0) begin
      $display("FAIL rst_on_boundary: data_out=%h valid_out=%b active=%b required 00/0/0", data_out, valid_out, active);
      n_fail++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    reset    = 1'b1;
    data_in  = 1'b0;
    test_reset();
    test_align_basic();
    test_junk_prefix();
    test_align_fail();
    test_back_to_back();
    test_reset_active();
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d bytes never received, required 0", exp_q.size());
      n_fail++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
